// File: rtl/eccop_mcu_pkg.sv
// Shared decode constants, test-mux and FSM encodings for the eccop_mcu_v2 sequencer.
package eccop_mcu_pkg;

    localparam logic [1:0] CLS_JUMP = 2'b11;
    localparam logic [3:0] CLS_CALL = 4'b1001;
    localparam logic [3:0] CLS_TSC  = 4'b1010;
    localparam logic [3:0] CLS_TSS  = 4'b1011;
    localparam logic [3:0] CLS_CTRL = 4'b1000;

    localparam logic [3:0] F_NOP  = 4'h0;
    localparam logic [3:0] F_RET  = 4'h1;
    localparam logic [3:0] F_DSZ  = 4'h2;
    localparam logic [3:0] F_LDLC = 4'h3;
    localparam logic [3:0] F_STOP = 4'hF;

    typedef enum logic [2:0] {
        TST_Z    = 3'd0,
        TST_C    = 3'd1,
        TST_CZ   = 3'd2,
        TST_CNZ  = 3'd3,
        TST_NCZ  = 3'd4,
        TST_NCNZ = 3'd5,
        TST_W0   = 3'd6,
        TST_LCZ  = 3'd7
    } test_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_EXEC     = 2'd2,
        ST_ALU_WAIT = 2'd3
    } state_e;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_STACK   = 1;

    function automatic logic test_eval(input logic [2:0] sel, input logic c, input logic z,
                                       input logic w0, input logic lcz);
        logic r;
        r = 1'b0;
        case (test_sel_e'(sel))
            TST_Z:    r = z;
            TST_C:    r = c;
            TST_CZ:   r = c & z;
            TST_CNZ:  r = c & ~z;
            TST_NCZ:  r = ~c & z;
            TST_NCNZ: r = ~c & ~z;
            TST_W0:   r = w0;
            TST_LCZ:  r = lcz;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/eccop_mcu_stack.sv
// Call/return LIFO; push when full and pop when empty are ignored and flagged.
module eccop_mcu_stack #(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [P_WIDTH-1:0] data_i,
    output logic [P_WIDTH-1:0] top_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               overflow_o,
    output logic               underflow_o
);
    localparam int SPW = $clog2(P_DEPTH + 1);
    localparam int IW  = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [SPW-1:0]     sp_q, sp_d;
    logic [P_WIDTH-1:0] mem_q [0:(1<<IW)-1];
    logic [IW-1:0]      wr_idx, rd_idx;

    assign full_o      = (sp_q == SPW'(P_DEPTH));
    assign empty_o     = (sp_q == '0);
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & empty_o;
    assign wr_idx      = IW'(sp_q);
    assign rd_idx      = IW'(sp_q - SPW'(1));
    assign top_o       = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr_i)
            sp_d = '0;
        else if (push_i && !full_o)
            sp_d = sp_q + SPW'(1);
        else if (pop_i && !empty_o)
            sp_d = sp_q - SPW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    always_ff @(posedge clk) begin
        if (!clr_i && push_i && !full_o)
            mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/eccop_mcu_v2.sv
// ECC-operation microsequencer with call stack, loop counter and sticky errors.
// Optional performance counters: define ECCOP_MCU_PERF_EN.
module eccop_mcu_v2
    import eccop_mcu_pkg::*;
#(
    parameter int P_MEMSIZE_LOG2 = 9,
    parameter int P_OPCODE_WIDTH = 8,
    parameter int P_STACK_DEPTH  = 4,
    parameter int P_LOOP_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [P_MEMSIZE_LOG2-1:0] opmem_waddr,
    input  logic [P_OPCODE_WIDTH-1:0] opmem_wdata,
    input  logic                      opmem_we,
    input  logic [P_MEMSIZE_LOG2-1:0] opmem_raddr,
    input  logic                      opmem_re,
    output logic [P_OPCODE_WIDTH-1:0] opmem_rdata,
    input  logic [P_MEMSIZE_LOG2-1:0] op_start_addr,
    input  logic                      op_start_en,
    input  logic                      op_start_wr,
    input  logic [P_LOOP_WIDTH-1:0]   loop_count_init,
    output logic [P_MEMSIZE_LOG2-1:0] op_pc,
    output logic                      op_running,
    output logic [1:0]                op_error,
`ifdef ECCOP_MCU_PERF_EN
    output logic [31:0]               op_instr_cnt,
    output logic [31:0]               op_alu_cnt,
`endif
    output logic [P_OPCODE_WIDTH-2:0] alu_op_code,
    input  logic                      alu_flags_carry,
    input  logic                      alu_flags_zero,
    input  logic                      alu_flags_w0,
    output logic                      alu_op_req,
    input  logic                      alu_op_ack
);
    localparam int A  = P_MEMSIZE_LOG2;
    localparam int W  = P_OPCODE_WIDTH;
    localparam int LW = P_LOOP_WIDTH;
    localparam logic [W-1:0] RSV_T = W'(((64'd1 << (W - 7)) - 64'd1) << 3);
    localparam logic [W-1:0] RSV_F = W'(((64'd1 << (W - 8)) - 64'd1) << 4);

    state_e         state_q, state_d;
    logic [A-1:0]   pc_q, pc_d;
    logic [W-1:0]   instr_q, rdata_q;
    logic [W-2:0]   alu_code_q, alu_code_d;
    logic           flag_c_q, flag_c_d, flag_z_q, flag_z_d, flag_w0_q, flag_w0_d;
    logic [LW-1:0]  lc_q, lc_d, lc_dec;
    logic [1:0]     err_q, err_d;
    logic [W-1:0]   mem_q [0:(1<<A)-1];

    logic           start_go, in_exec, is_call, is_ret, ack_take, tst;
    logic           stk_full, stk_empty, stk_ovf, stk_unf;
    logic [A-1:0]   stk_top, pc_inc1, pc_inc2;
    logic signed [31:0] jofs32, cofs32;

    assign start_go = op_start_wr & op_start_en;
    assign in_exec  = (state_q == ST_EXEC) && !op_start_wr;
    assign is_call  = in_exec && (instr_q[W-1 -: 4] == CLS_CALL);
    assign is_ret   = in_exec && (instr_q[W-1 -: 4] == CLS_CTRL) &&
                      ((instr_q & RSV_F) == '0) && (instr_q[3:0] == F_RET);
    assign ack_take = (state_q == ST_ALU_WAIT) && alu_op_ack && !op_start_wr;

    assign pc_inc1 = pc_q + A'(1);
    assign pc_inc2 = pc_q + A'(2);
    assign jofs32  = 32'(signed'(instr_q[W-3:0]));
    assign cofs32  = 32'(signed'(instr_q[W-5:0]));
    assign lc_dec  = lc_q - LW'(1);
    assign tst     = test_eval(instr_q[2:0], flag_c_q, flag_z_q, flag_w0_q, lc_q == '0);

    eccop_mcu_stack #(
        .P_DEPTH (P_STACK_DEPTH),
        .P_WIDTH (A)
    ) u_stack (
        .clk         (clk),
        .rst_n       (reset_n),
        .clr_i       (start_go),
        .push_i      (is_call),
        .pop_i       (is_ret),
        .data_i      (pc_inc1),
        .top_o       (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty),
        .overflow_o  (stk_ovf),
        .underflow_o (stk_unf)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        alu_code_d = alu_code_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        flag_w0_d  = flag_w0_q;
        lc_d       = lc_q;
        err_d      = err_q;
        if (op_start_wr) begin
            // start and abort take priority over whatever is in flight
            if (op_start_en) begin
                state_d   = ST_FETCH;
                pc_d      = op_start_addr;
                err_d     = '0;
                flag_c_d  = 1'b0;
                flag_z_d  = 1'b0;
                flag_w0_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_EXEC;
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    if (!instr_q[W-1]) begin
                        alu_code_d = instr_q[W-2:0];
                        state_d    = ST_ALU_WAIT;
                    end else if (instr_q[W-1 -: 2] == CLS_JUMP) begin
                        pc_d = pc_q + jofs32[A-1:0];
                    end else begin
                        case (instr_q[W-1 -: 4])
                            CLS_CALL: begin
                                if (stk_ovf) begin
                                    err_d[ERR_STACK] = 1'b1;
                                    state_d          = ST_IDLE;
                                end else begin
                                    pc_d = pc_q + cofs32[A-1:0];
                                end
                            end
                            CLS_TSC, CLS_TSS: begin
                                if ((instr_q & RSV_T) != '0) begin
                                    err_d[ERR_ILLEGAL] = 1'b1;
                                    state_d            = ST_IDLE;
                                end else begin
                                    // bit W-4 selects TSS (skip on true) vs TSC (skip on false)
                                    pc_d = (tst == instr_q[W-4]) ? pc_inc2 : pc_inc1;
                                end
                            end
                            CLS_CTRL: begin
                                if ((instr_q & RSV_F) != '0) begin
                                    err_d[ERR_ILLEGAL] = 1'b1;
                                    state_d            = ST_IDLE;
                                end else begin
                                    case (instr_q[3:0])
                                        F_NOP: pc_d = pc_inc1;
                                        F_RET: begin
                                            if (stk_unf) begin
                                                err_d[ERR_STACK] = 1'b1;
                                                state_d          = ST_IDLE;
                                            end else begin
                                                pc_d = stk_top;
                                            end
                                        end
                                        F_DSZ: begin
                                            lc_d = lc_dec;
                                            pc_d = (lc_dec == '0) ? pc_inc2 : pc_inc1;
                                        end
                                        F_LDLC: begin
                                            lc_d = loop_count_init;
                                            pc_d = pc_inc1;
                                        end
                                        F_STOP: state_d = ST_IDLE;
                                        default: begin
                                            err_d[ERR_ILLEGAL] = 1'b1;
                                            state_d            = ST_IDLE;
                                        end
                                    endcase
                                end
                            end
                            default: begin
                                err_d[ERR_ILLEGAL] = 1'b1;
                                state_d            = ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_ALU_WAIT: begin
                    if (alu_op_ack) begin
                        flag_c_d  = alu_flags_carry;
                        flag_z_d  = alu_flags_zero;
                        flag_w0_d = alu_flags_w0;
                        pc_d      = pc_inc1;
                        state_d   = ST_FETCH;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            alu_code_q <= '0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_w0_q  <= 1'b0;
            lc_q       <= '0;
            err_q      <= '0;
            instr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            alu_code_q <= alu_code_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            flag_w0_q  <= flag_w0_d;
            lc_q       <= lc_d;
            err_q      <= err_d;
            if (state_q == ST_FETCH)
                instr_q <= mem_q[pc_q];
            if (opmem_re)
                rdata_q <= mem_q[opmem_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (opmem_we)
            mem_q[opmem_waddr] <= opmem_wdata;
    end

`ifdef ECCOP_MCU_PERF_EN
    logic [31:0] instr_cnt_q, alu_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt_q <= '0;
            alu_cnt_q   <= '0;
        end else if (start_go) begin
            instr_cnt_q <= '0;
            alu_cnt_q   <= '0;
        end else begin
            if (in_exec && instr_cnt_q != '1)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (ack_take && alu_cnt_q != '1)
                alu_cnt_q <= alu_cnt_q + 32'd1;
        end
    end

    assign op_instr_cnt = instr_cnt_q;
    assign op_alu_cnt   = alu_cnt_q;
`endif

    assign opmem_rdata = rdata_q;
    assign op_pc       = pc_q;
    assign op_running  = (state_q != ST_IDLE);
    assign op_error    = err_q;
    assign alu_op_code = alu_code_q;
    // a start/abort strobe withdraws the request in the same cycle
    assign alu_op_req  = (state_q == ST_ALU_WAIT) && !op_start_wr;

endmodule
